reset_button_controller: RTL and testbench

Sequencing front-end for the console reset line. It debounces the raw reset button, classifies each press as a tap (plain reset) or a hold (region select), and cycles the region index while the button is held. It then issues a single start request, with the correct pattern, to the downstream reset pulse driver. It owns the `drv_start`/`drv_pattern` inputs of that driver and never re-triggers it while the driver reports busy.

---
 rtl/snes_ctrl_pkg.sv | 30 +++
 rtl/button_debouncer.sv | 41 ++++
 rtl/reset_button_controller.sv | 145 ++++++++++++++
 tb/tb_reset_button_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_ctrl_pkg.sv
// Shared types and constants for the console front-panel reset sequencing logic.
// Holds the controller FSM encoding, region codes, reset pattern codes and small helpers.
package snes_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HELD   = 3'd1,
      SELECT = 3'd2,
      ISSUE  = 3'd3,
      WAIT   = 3'd4
   } state_t;

   localparam logic [1:0] REGION_NTSC_U = 2'd0;
   localparam logic [1:0] REGION_PAL    = 2'd1;
   localparam logic [1:0] REGION_NTSC_J = 2'd2;

   localparam logic PATTERN_SHORT = 1'b0;
   localparam logic PATTERN_LONG  = 1'b1;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == '1) ? value : value + 32'd1;
   endfunction

   function automatic logic [1:0] next_region(input logic [1:0] cur, input int unsigned num);
      if ({30'd0, cur} >= num - 32'd1) return 2'd0;
      return cur + 2'd1;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stability counter for an active-low front-panel button.
// The debounced level follows the input only after it has held a new value for DEBOUNCE_TICKS cycles.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_TICKS = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic pressed
);

   logic        sync_1;
   logic        sync_2;
   logic [31:0] stable_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= ~btn_n;
         sync_2 <= sync_1;
      end
   end

   // Any cycle where the synchronized level agrees with the output restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_cnt <= '0;
         pressed    <= 1'b0;
      end else if (sync_2 == pressed) begin
         stable_cnt <= '0;
      end else if (stable_cnt >= DEBOUNCE_TICKS - 32'd1) begin
         stable_cnt <= '0;
         pressed    <= sync_2;
      end else begin
         stable_cnt <= stable_cnt + 32'd1;
      end
   end

endmodule

// File: rtl/reset_button_controller.sv
// Classifies debounced reset-button presses into taps and region-select holds and issues
// exactly one start request per accepted press to the downstream reset pulse driver.
module reset_button_controller
   import snes_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = 1_000_000,
   parameter int unsigned HOLD_TICKS     = 37_500_000,
   parameter int unsigned CYCLE_TICKS    = 50_000_000,
   parameter int unsigned NUM_REGIONS    = 3,
   parameter int unsigned DEFAULT_REGION = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_n,
   input  logic       uigr_en,
   input  logic       drv_busy,
   output logic       drv_start,
   output logic       drv_pattern,
   output logic [1:0] region,
   output logic       selecting,
   output logic [1:0] cand,
   output state_t     fsm_state
);

   localparam logic [1:0] DEF_REGION = 2'(DEFAULT_REGION);

   logic        pressed;
   logic        armed;
   state_t      state, state_nx;
   logic [31:0] hold_cnt, hold_cnt_nx;
   logic [31:0] cycle_cnt, cycle_cnt_nx;
   logic [1:0]  region_nx;
   logic [1:0]  cand_q, cand_nx;
   logic        pend_pattern, pend_pattern_nx;
   logic        busy_seen, busy_seen_nx;
   logic        drv_start_nx;
   logic        drv_pattern_nx;

   button_debouncer #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
   ) u_debouncer (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_n  (btn_n),
      .pressed(pressed)
   );

   always_comb begin
      state_nx        = state;
      hold_cnt_nx     = hold_cnt;
      cycle_cnt_nx    = cycle_cnt;
      region_nx       = region;
      cand_nx         = cand_q;
      pend_pattern_nx = pend_pattern;
      busy_seen_nx    = busy_seen;
      drv_start_nx    = 1'b0;
      drv_pattern_nx  = drv_pattern;
      case (state)
         IDLE: begin
            if (pressed && armed) begin
               state_nx    = HELD;
               hold_cnt_nx = '0;
            end
         end
         HELD: begin
            // Reaching the hold threshold wins over a release seen in the same cycle.
            if (hold_cnt >= HOLD_TICKS) begin
               state_nx     = SELECT;
               cand_nx      = region;
               cycle_cnt_nx = '0;
            end else if (!pressed) begin
               state_nx        = ISSUE;
               pend_pattern_nx = PATTERN_SHORT;
            end else begin
               hold_cnt_nx = sat_inc(hold_cnt);
            end
         end
         SELECT: begin
            if (!pressed) begin
               if (cand_q != region) begin
                  region_nx       = cand_q;
                  pend_pattern_nx = uigr_en ? PATTERN_LONG : PATTERN_SHORT;
                  state_nx        = ISSUE;
               end else begin
                  state_nx = IDLE;
               end
            end else if (sat_inc(cycle_cnt) >= CYCLE_TICKS) begin
               cand_nx      = next_region(cand_q, NUM_REGIONS);
               cycle_cnt_nx = '0;
            end else begin
               cycle_cnt_nx = sat_inc(cycle_cnt);
            end
         end
         ISSUE: begin
            if (!drv_busy) begin
               drv_start_nx   = 1'b1;
               drv_pattern_nx = pend_pattern;
               busy_seen_nx   = 1'b0;
               state_nx       = WAIT;
            end
         end
         WAIT: begin
            // The driver must acknowledge with busy before its falling edge means done.
            if (!busy_seen) begin
               if (drv_busy) busy_seen_nx = 1'b1;
            end else if (!drv_busy) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         hold_cnt     <= '0;
         cycle_cnt    <= '0;
         region       <= DEF_REGION;
         cand_q       <= DEF_REGION;
         pend_pattern <= PATTERN_SHORT;
         busy_seen    <= 1'b0;
         drv_start    <= 1'b0;
         drv_pattern  <= PATTERN_SHORT;
         armed        <= 1'b1;
      end else begin
         state        <= state_nx;
         hold_cnt     <= hold_cnt_nx;
         cycle_cnt    <= cycle_cnt_nx;
         region       <= region_nx;
         cand_q       <= cand_nx;
         pend_pattern <= pend_pattern_nx;
         busy_seen    <= busy_seen_nx;
         drv_start    <= drv_start_nx;
         drv_pattern  <= drv_pattern_nx;
         // A press is only accepted once the button has been seen released.
         armed        <= ~pressed;
      end
   end

   assign selecting = (state == SELECT);
   assign cand      = selecting ? cand_q : region;
   assign fsm_state = state;

endmodule

// File: tb/tb_reset_button_controller.sv
// Randomized self-checking bench for reset_button_controller with a timeline-level press model.
module tb_reset_button_controller;
   import snes_ctrl_pkg::*;

   localparam int DEB      = 4;
   localparam int HOLD     = 20;
   localparam int CYC      = 10;
   localparam int NREG     = 3;
   localparam int BUSY_LEN = 8;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b0;
   logic       btn_n      = 1'b1;
   logic       uigr_en    = 1'b1;
   logic       busy_force = 1'b0;
   logic       drv_busy;
   logic       drv_start;
   logic       drv_pattern;
   logic [1:0] region;
   logic       selecting;
   logic [1:0] cand;
   state_t     fsm_state;

   int   cyc      = 0;
   int   busy_cnt = 0;
   int   errors   = 0;
   int   checks   = 0;
   int   exp_region = 0;
   int   start_cyc_q[$];
   logic start_pat_q[$];

   reset_button_controller #(
      .DEBOUNCE_TICKS(DEB),
      .HOLD_TICKS    (HOLD),
      .CYCLE_TICKS   (CYC),
      .NUM_REGIONS   (NREG),
      .DEFAULT_REGION(0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_n      (btn_n),
      .uigr_en    (uigr_en),
      .drv_busy   (drv_busy),
      .drv_start  (drv_start),
      .drv_pattern(drv_pattern),
      .region     (region),
      .selecting  (selecting),
      .cand       (cand),
      .fsm_state  (fsm_state)
   );

   // clock / cycle counter / driver model
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)             busy_cnt <= 0;
      else if (drv_start)     busy_cnt <= BUSY_LEN;
      else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
   end
   assign drv_busy = busy_force | (busy_cnt != 0);

   always @(negedge clk) begin
      if (rst_n && drv_start) begin
         start_cyc_q.push_back(cyc);
         start_pat_q.push_back(drv_pattern);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (drv_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %0b want 0", drv_start); end
      checks++; if (drv_pattern !== 1'b0) begin errors++; $display("FAIL rst_pattern: got %0b want 0", drv_pattern); end
      checks++; if (selecting !== 1'b0) begin errors++; $display("FAIL rst_selecting: got %0b want 0", selecting); end
      checks++; if (region !== 2'd0) begin errors++; $display("FAIL rst_region: got %0d want 0", region); end
      checks++; if (cand !== 2'd0) begin errors++; $display("FAIL rst_cand: got %0d want 0", cand); end
      checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want IDLE", fsm_state); end
      rst_n = 1'b1;
      repeat (3) tick();
      checks++; if (fsm_state !== IDLE || drv_start !== 1'b0) begin
         errors++; $display("FAIL post_rst_idle: state=%0d start=%0b want IDLE/0", fsm_state, drv_start);
      end
      exp_region = 0;
   endtask

   // One press of t_len debounced cycles, checked every cycle against the press timeline model.
   task automatic run_press(input int t_len, input bit bounce, input string name);
      int t0, e0, r_e, f_e, s_e, rel_e, d, adv, commit, st_e, end_e, r0;
      bit tap, issue, sel_e, low;
      logic pat;
      logic [1:0] cand_e, reg_e;
      r0 = exp_region;
      start_cyc_q.delete();
      start_pat_q.delete();
      t0    = cyc;
      e0    = t0 + 2;
      r_e   = e0 + DEB + 2;
      f_e   = e0 + t_len + DEB + 2;
      s_e   = r_e + 2 + HOLD;
      tap   = (t_len <= HOLD);
      d     = t_len - 1 - HOLD;
      rel_e = (d >= 1) ? f_e + 1 : s_e + 1;
      adv   = tap ? 0 : (((d > 1) ? d : 1) - 1) / CYC;
      commit = (r0 + adv) % NREG;
      issue = tap || (commit != r0);
      pat   = tap ? PATTERN_SHORT : uigr_en;
      st_e  = f_e + 2;
      end_e = f_e + 20;
      for (int c = t0; c <= end_e; c++) begin
         if (c > t0) begin
            sel_e  = !tap && c >= s_e && c < rel_e;
            reg_e  = 2'((!tap && c >= rel_e) ? commit : r0);
            cand_e = sel_e ? 2'((r0 + (c - s_e) / CYC) % NREG) : reg_e;
            checks++; if (selecting !== sel_e) begin errors++; $display("FAIL %s_selecting: got %0b want %0b at cycle %0d", name, selecting, sel_e, c - e0); end
            checks++; if (region !== reg_e) begin errors++; $display("FAIL %s_region: got %0d want %0d at cycle %0d", name, region, reg_e, c - e0); end
            checks++; if (cand !== cand_e) begin errors++; $display("FAIL %s_cand: got %0d want %0d at cycle %0d", name, cand, cand_e, c - e0); end
            checks++; if (drv_start !== (issue && c == st_e)) begin errors++; $display("FAIL %s_start: got %0b want %0b at cycle %0d", name, drv_start, issue && c == st_e, c - e0); end
            if (issue && c == st_e) begin
               checks++; if (drv_pattern !== pat) begin errors++; $display("FAIL %s_pattern: got %0b want %0b", name, drv_pattern, pat); end
            end
         end
         low = (c >= e0 && c < e0 + t_len) || (bounce && c == e0 - 2);
         if (bounce && c == e0 + t_len - 2) low = 1'b0;
         btn_n = ~low;
         tick();
      end
      checks++; if (start_cyc_q.size() != (issue ? 1 : 0)) begin errors++; $display("FAIL %s_start_count: got %0d want %0d", name, start_cyc_q.size(), issue ? 1 : 0); end
      checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL %s_end_state: got %0d want IDLE", name, fsm_state); end
      if (issue) begin
         checks++; if (drv_pattern !== pat) begin errors++; $display("FAIL %s_pattern_hold: got %0b want %0b", name, drv_pattern, pat); end
      end
      exp_region = tap ? r0 : commit;
   endtask

   task automatic test_tap();
      uigr_en = 1'b1;
      run_press(10, 1'b1, "tap");
   endtask

   task automatic test_hold_commit();
      uigr_en = 1'b1;
      run_press(HOLD + 25, 1'b0, "hold_commit");
      checks++; if (region !== 2'd2) begin errors++; $display("FAIL hold_commit_final: got %0d want 2", region); end
   endtask

   task automatic test_wrap_cancel();
      uigr_en = 1'b1;
      run_press(HOLD + 35, 1'b0, "wrap_cancel");
   endtask

   task automatic test_reset_midselect();
      int e0, rr;
      start_cyc_q.delete();
      start_pat_q.delete();
      e0 = cyc;
      btn_n = 1'b0;
      repeat (42) tick();
      // SELECT entered at e0+DEB+4+HOLD, one advance by e0+42 from region 0.
      checks++; if (selecting !== 1'b1 || cand !== 2'd1) begin
         errors++; $display("FAIL midsel_setup: selecting=%0b cand=%0d want 1/1", selecting, cand);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (selecting !== 1'b0) begin errors++; $display("FAIL midsel_selecting: got %0b want 0", selecting); end
      checks++; if (region !== 2'd0 || cand !== 2'd0) begin errors++; $display("FAIL midsel_region: region=%0d cand=%0d want 0/0", region, cand); end
      checks++; if (drv_start !== 1'b0 || fsm_state !== IDLE) begin errors++; $display("FAIL midsel_idle: start=%0b state=%0d want 0/IDLE", drv_start, fsm_state); end
      repeat (3) begin
         tick();
         checks++; if (drv_start !== 1'b0) begin errors++; $display("FAIL midsel_in_reset_start: got %0b want 0", drv_start); end
      end
      rst_n = 1'b1;
      rr = cyc;
      for (int i = 0; i < 15; i++) begin
         tick();
         checks++; if (drv_start !== 1'b0 || selecting !== 1'b0) begin
            errors++; $display("FAIL midsel_held: start=%0b selecting=%0b want 0/0 at %0d", drv_start, selecting, i);
         end
      end
      btn_n = 1'b1;
      repeat (35) tick();
      checks++; if (start_cyc_q.size() != 1) begin
         errors++; $display("FAIL midsel_tap_count: got %0d want 1", start_cyc_q.size());
      end else begin
         checks++; if (start_cyc_q[0] != rr + 15 + DEB + 4 || start_pat_q[0] !== 1'b0) begin
            errors++; $display("FAIL midsel_tap: cycle=%0d pat=%0b want %0d/0", start_cyc_q[0] - rr, start_pat_q[0], 15 + DEB + 4);
         end
      end
      exp_region = 0;
   endtask

   task automatic test_uigr_off();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      exp_region = 0;
      uigr_en = 1'b0;
      run_press(HOLD + 15, 1'b0, "uigr_off");
      checks++; if (region !== 2'd1) begin errors++; $display("FAIL uigr_off_region: got %0d want 1", region); end
      uigr_en = 1'b1;
   endtask

   task automatic test_busy_wait();
      int e0, f_e, b_e;
      start_cyc_q.delete();
      start_pat_q.delete();
      busy_force = 1'b1;
      repeat (2) tick();
      e0  = cyc;
      f_e = e0 + 10 + DEB + 2;
      b_e = f_e + 30;
      btn_n = 1'b0;
      while (cyc < b_e) begin
         if (cyc == e0 + 10) btn_n = 1'b1;
         tick();
         checks++; if (drv_start !== 1'b0) begin errors++; $display("FAIL busy_early_start: got %0b want 0 at %0d", drv_start, cyc - e0); end
      end
      busy_force = 1'b0;
      tick();
      tick();
      btn_n = 1'b0;
      repeat (12) tick();
      btn_n = 1'b1;
      repeat (40) tick();
      checks++; if (start_cyc_q.size() != 1) begin
         errors++; $display("FAIL busy_start_count: got %0d want 1", start_cyc_q.size());
      end else begin
         checks++; if (start_cyc_q[0] != b_e + 1 || start_pat_q[0] !== 1'b0) begin
            errors++; $display("FAIL busy_start: cycle=%0d pat=%0b want %0d/0", start_cyc_q[0] - e0, start_pat_q[0], b_e + 1 - e0);
         end
      end
      checks++; if (fsm_state !== IDLE || region !== 2'(exp_region)) begin
         errors++; $display("FAIL busy_end: state=%0d region=%0d want IDLE/%0d", fsm_state, region, exp_region);
      end
   endtask

   task automatic test_random_presses();
      int lens[$];
      lens.push_back(HOLD);
      lens.push_back(HOLD + 1);
      for (int i = 0; i < 8; i++) lens.push_back($urandom_range(70, DEB + 1));
      foreach (lens[i]) begin
         uigr_en = 1'($urandom_range(1, 0));
         run_press(lens[i], 1'b0, "random");
         repeat ($urandom_range(6, 2)) tick();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      btn_n = 1'b1;
      repeat (3) tick();
      test_reset();
      test_tap();
      test_reset_midselect();
      test_hold_commit();
      test_wrap_cancel();
      test_uigr_off();
      test_busy_wait();
      test_random_presses();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
